// File: rtl/sa_input_skew_if.sv
// Operand handshake and skewed lane bus between an upstream vector source,
// the input-skew feeder, and the systolic array edge PEs.
interface sa_input_skew_if #(
  parameter int ARRAY_N = 4,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [ARRAY_N*DATA_W-1:0] in_data;
  logic                      in_last;
  logic [ARRAY_N-1:0]        lane_valid;
  logic [ARRAY_N*DATA_W-1:0] lane_data;
  logic                      tile_done;
  logic [CNT_W-1:0]          beat_cnt;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, lane_valid, lane_data, tile_done, beat_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, lane_valid, lane_data, tile_done, beat_cnt
  );
endinterface

// File: rtl/sa_input_skew.sv
// Diagonal input skew feeder for a systolic array edge: lane i lags lane 0 by
// i cycles, with a tile FSM that blocks input while the last beat drains.
module sa_input_skew #(
  parameter int ARRAY_N = 4,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  sa_input_skew_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  // The flush counter only ever holds ARRAY_N-2 down to 0.
  localparam int FLUSH_W    = (ARRAY_N > 2) ? $clog2(ARRAY_N - 1) : 1;
  localparam int FLUSH_INIT = (ARRAY_N > 1) ? ARRAY_N - 2 : 0;

  state_t               state_q, state_d;
  logic [FLUSH_W-1:0]   flush_q, flush_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 hs;

  assign bus.in_ready  = (state_q == IDLE) || (state_q == STREAM);
  assign bus.tile_done = (state_q == DONE);
  assign bus.beat_cnt  = cnt_q;
  assign hs            = bus.in_valid && bus.in_ready;

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    case (state_q)
      IDLE, STREAM: begin
        if (bus.in_valid) begin
          if (bus.in_last) begin
            state_d = (ARRAY_N == 1) ? DONE : FLUSH;
            flush_d = FLUSH_W'(FLUSH_INIT);
          end else begin
            state_d = STREAM;
          end
        end
      end
      FLUSH: begin
        if (flush_q == '0) state_d = DONE;
        else               flush_d = flush_q - FLUSH_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flush_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      if (state_q == DONE)          cnt_q <= '0;
      else if (hs && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Lane i is an (i+1)-deep {valid, data} delay line; bubbles enter as zeros,
  // so lane_data is zero whenever lane_valid is low.
  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    logic              v_q [i+1];
    logic [DATA_W-1:0] d_q [i+1];

    always_ff @(posedge clk) begin
      // NOTE: the delay lines are reset (not just their valids) so an aborted tile leaves no stale data.
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) begin
          v_q[j] <= 1'b0;
          d_q[j] <= '0;
        end
      end else begin
        v_q[0] <= hs;
        d_q[0] <= hs ? bus.in_data[i*DATA_W +: DATA_W] : '0;
        for (int j = 1; j <= i; j++) begin
          v_q[j] <= v_q[j-1];
          d_q[j] <= d_q[j-1];
        end
      end
    end

    assign bus.lane_valid[i]                 = v_q[i];
    assign bus.lane_data[i*DATA_W +: DATA_W] = d_q[i];
  end

endmodule

// File: tb/tb_sa_input_skew.sv
// Directed table-driven bench for sa_input_skew (ARRAY_N=4), plus a
// single-lane instance with a 2-bit beat counter for saturation.
module tb_sa_input_skew;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_input_skew_if #(.ARRAY_N(4), .DATA_W(16), .CNT_W(16)) bus ();
  sa_input_skew_if #(.ARRAY_N(1), .DATA_W(16), .CNT_W(2))  bus1 ();

  sa_input_skew #(.ARRAY_N(4), .DATA_W(16), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  sa_input_skew #(.ARRAY_N(1), .DATA_W(16), .CNT_W(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic        last;
    logic [63:0] din;
    logic [3:0]  lv;
    logic [63:0] ld;
    logic        rdy;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [63:0] GARB = 64'hFFFF_EEEE_DDDD_CCCC;

  function automatic logic [63:0] lanes(input logic [15:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic void add(input logic r, v, l, input logic [63:0] din,
                              input logic [3:0] lv, input logic [63:0] ld,
                              input logic rdy, done, input logic [15:0] cnt);
    vec_t e;
    e.rst_n = r; e.vld = v; e.last = l; e.din = din;
    e.lv = lv; e.ld = ld; e.rdy = rdy; e.done = done; e.cnt = cnt;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step1(input logic v, input logic l, input logic [15:0] d);
    @(negedge clk);
    bus1.in_valid = v;
    bus1.in_last  = l;
    bus1.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    bus1.in_data  = '0;

    // Each row: inputs applied before an edge, outputs expected just after it.
    // Reset, then idle.
    add(0,0,0,0,            4'b0000, 0,                         1,0,0);
    add(1,0,0,0,            4'b0000, 0,                         1,0,0);
    // Single beat with last: skew 1..4 cycles, valid-with-ready-low ignored.
    add(1,1,1,lanes(4,3,2,1), 4'b0001, lanes(0,0,0,1),          0,0,1);
    add(1,1,0,GARB,         4'b0010, lanes(0,0,2,0),            0,0,1);
    add(1,0,0,0,            4'b0100, lanes(0,3,0,0),            0,0,1);
    add(1,0,0,0,            4'b1000, lanes(4,0,0,0),            0,1,1);
    add(1,0,0,0,            4'b0000, 0,                         1,0,0);
    // Three-beat tile, continuous valid.
    add(1,1,0,lanes('h31,'h21,'h11,'h01), 4'b0001, lanes(0,0,0,'h01),       1,0,1);
    add(1,1,0,lanes('h32,'h22,'h12,'h02), 4'b0011, lanes(0,0,'h11,'h02),    1,0,2);
    add(1,1,1,lanes('h33,'h23,'h13,'h03), 4'b0111, lanes(0,'h21,'h12,'h03), 0,0,3);
    add(1,0,0,0,            4'b1110, lanes('h31,'h22,'h13,0),   0,0,3);
    add(1,0,0,0,            4'b1100, lanes('h32,'h23,0,0),      0,0,3);
    add(1,0,0,0,            4'b1000, lanes('h33,0,0,0),         0,1,3);
    add(1,0,0,0,            4'b0000, 0,                         1,0,0);
    // Bubble between beats; in_last with valid low is ignored.
    add(1,1,0,lanes('hA3,'hA2,'hA1,'hA0), 4'b0001, lanes(0,0,0,'hA0),      1,0,1);
    add(1,0,1,GARB,         4'b0010, lanes(0,0,'hA1,0),         1,0,1);
    add(1,1,1,lanes('hB3,'hB2,'hB1,'hB0), 4'b0101, lanes(0,'hA2,0,'hB0),   0,0,2);
    add(1,0,0,0,            4'b1010, lanes('hA3,0,'hB1,0),      0,0,2);
    add(1,0,0,0,            4'b0100, lanes(0,'hB2,0,0),         0,0,2);
    add(1,0,0,0,            4'b1000, lanes('hB3,0,0,0),         0,1,2);
    add(1,0,0,0,            4'b0000, 0,                         1,0,0);
    // Reset during FLUSH of a two-beat tile, then a fresh tile.
    add(1,1,0,lanes('hC3,'hC2,'hC1,'hC0), 4'b0001, lanes(0,0,0,'hC0),      1,0,1);
    add(1,1,1,lanes('hD3,'hD2,'hD1,'hD0), 4'b0011, lanes(0,0,'hC1,'hD0),   0,0,2);
    add(0,0,0,0,            4'b0000, 0,                         1,0,0);
    add(1,0,0,0,            4'b0000, 0,                         1,0,0);
    add(1,0,0,0,            4'b0000, 0,                         1,0,0);
    add(1,0,0,0,            4'b0000, 0,                         1,0,0);
    add(1,1,1,lanes(8,7,6,5), 4'b0001, lanes(0,0,0,5),          0,0,1);
    add(1,0,0,0,            4'b0010, lanes(0,0,6,0),            0,0,1);
    add(1,0,0,0,            4'b0100, lanes(0,7,0,0),            0,0,1);
    add(1,0,0,0,            4'b1000, lanes(8,0,0,0),            0,1,1);
    add(1,0,0,0,            4'b0000, 0,                         1,0,0);
    // in_valid held high: nothing accepted in FLUSH/DONE, next beat after DONE.
    add(1,1,0,lanes('hE13,'hE12,'hE11,'hE10), 4'b0001, lanes(0,0,0,'hE10),        1,0,1);
    add(1,1,1,lanes('hE23,'hE22,'hE21,'hE20), 4'b0011, lanes(0,0,'hE11,'hE20),    0,0,2);
    add(1,1,0,lanes('hF3,'hF2,'hF1,'hF0), 4'b0110, lanes(0,'hE12,'hE21,0),        0,0,2);
    add(1,1,0,lanes('hF3,'hF2,'hF1,'hF0), 4'b1100, lanes('hE13,'hE22,0,0),        0,0,2);
    add(1,1,0,lanes('hF3,'hF2,'hF1,'hF0), 4'b1000, lanes('hE23,0,0,0),            0,1,2);
    add(1,1,1,lanes('hF3,'hF2,'hF1,'hF0), 4'b0000, 0,                             1,0,0);
    add(1,1,1,lanes('hF3,'hF2,'hF1,'hF0), 4'b0001, lanes(0,0,0,'hF0),             0,0,1);
    add(1,0,0,0,            4'b0010, lanes(0,0,'hF1,0),         0,0,1);
    add(1,0,0,0,            4'b0100, lanes(0,'hF2,0,0),         0,0,1);
    add(1,0,0,0,            4'b1000, lanes('hF3,0,0,0),         0,1,1);
    add(1,0,0,0,            4'b0000, 0,                         1,0,0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst_n        = vecs[k].rst_n;
      bus.in_valid = vecs[k].vld;
      bus.in_last  = vecs[k].last;
      bus.in_data  = vecs[k].din;
      @(posedge clk);
      #1;
      check($sformatf("row%0d lane_valid", k), 64'(bus.lane_valid), 64'(vecs[k].lv));
      check($sformatf("row%0d lane_data",  k), bus.lane_data,       vecs[k].ld);
      check($sformatf("row%0d in_ready",   k), 64'(bus.in_ready),   64'(vecs[k].rdy));
      check($sformatf("row%0d tile_done",  k), 64'(bus.tile_done),  64'(vecs[k].done));
      check($sformatf("row%0d beat_cnt",   k), 64'(bus.beat_cnt),   64'(vecs[k].cnt));
    end

    // Single-lane instance: counter saturates at 3, DONE follows the last beat directly.
    for (int b = 1; b <= 4; b++) begin
      step1(1'b1, 1'b0, 16'(16'h0100 + b));
      check($sformatf("n1 beat%0d lane_valid", b), 64'(bus1.lane_valid), 64'd1);
      check($sformatf("n1 beat%0d lane_data",  b), 64'(bus1.lane_data),  64'(16'h0100 + b));
      check($sformatf("n1 beat%0d beat_cnt",   b), 64'(bus1.beat_cnt),   64'((b > 3) ? 3 : b));
      check($sformatf("n1 beat%0d in_ready",   b), 64'(bus1.in_ready),   64'd1);
    end
    step1(1'b1, 1'b1, 16'h0105);
    check("n1 last lane_data", 64'(bus1.lane_data), 64'h0105);
    check("n1 last tile_done", 64'(bus1.tile_done), 64'd1);
    check("n1 last beat_cnt",  64'(bus1.beat_cnt),  64'd3);
    check("n1 last in_ready",  64'(bus1.in_ready),  64'd0);
    step1(1'b1, 1'b0, 16'h0106);
    check("n1 idle lane_valid", 64'(bus1.lane_valid), 64'd0);
    check("n1 idle tile_done",  64'(bus1.tile_done),  64'd0);
    check("n1 idle beat_cnt",   64'(bus1.beat_cnt),   64'd0);
    check("n1 idle in_ready",   64'(bus1.in_ready),   64'd1);
    step1(1'b0, 1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
